// File: rtl/keyboard_mover_if.sv
// Key-event, frame-timing, load and sprite-position bundle for keyboard_mover.
interface keyboard_mover_if #(
    parameter int unsigned POS_W = 12
);
    logic             ascii_new;
    logic [6:0]       ascii_out;
    logic [10:0]      hcount;
    logic [10:0]      vcount;
    logic             pos_load;
    logic [POS_W-1:0] x_pos_in;
    logic [POS_W-1:0] y_pos_in;
    logic [POS_W-1:0] x_pos_k;
    logic [POS_W-1:0] y_pos_k;
    logic             space;
    logic             fire;
    logic             moving;

    // Producer of key events / timing / loads; consumer of the sprite state
    modport master (
        output ascii_new, ascii_out, hcount, vcount, pos_load, x_pos_in, y_pos_in,
        input  x_pos_k, y_pos_k, space, fire, moving
    );

    // The motion controller itself
    modport slave (
        input  ascii_new, ascii_out, hcount, vcount, pos_load, x_pos_in, y_pos_in,
        output x_pos_k, y_pos_k, space, fire, moving
    );
endinterface

// File: rtl/keyboard_mover.sv
// Frame-synchronous WASD sprite mover with hold timeout, step acceleration,
// per-axis clamping, explicit position load and a one-shot fire pulse.
module keyboard_mover #(
    parameter int unsigned POS_W        = 12,
    parameter int unsigned X_MIN        = 1,
    parameter int unsigned X_MAX        = 763,
    parameter int unsigned Y_MIN        = 1,
    parameter int unsigned Y_MAX        = 563,
    parameter int unsigned X_RST        = 380,
    parameter int unsigned Y_RST        = 500,
    parameter int unsigned STEP         = 2,
    parameter int unsigned STEP_MAX     = 8,
    parameter int unsigned ACCEL_FRAMES = 16,
    parameter int unsigned HOLD_FRAMES  = 6,
    parameter int unsigned H_LAST       = 799,
    parameter int unsigned V_LAST       = 599
) (
    input  logic             clk,
    input  logic             rst,
    keyboard_mover_if.slave  bus
);
    localparam int unsigned EXT_W  = POS_W + 1;
    localparam int unsigned HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int unsigned RUN_W  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam int unsigned STEP_W = $clog2(STEP_MAX + 1);
    localparam int unsigned SUM_W  = STEP_W + 1;

    typedef enum logic {S_IDLE, S_MOVE} state_t;
    typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_t;

    state_t              state, state_nxt;
    dir_t                dir, dir_nxt;
    logic [HOLD_W-1:0]   dir_hold, dir_hold_nxt;
    logic [HOLD_W-1:0]   space_hold, space_hold_nxt;
    logic                fire_req, fire_req_nxt;
    logic [STEP_W-1:0]   step_cur, step_nxt;
    logic [RUN_W-1:0]    run_cnt, run_cnt_nxt;
    logic [POS_W-1:0]    x_pos, x_nxt;
    logic [POS_W-1:0]    y_pos, y_nxt;
    logic                space_q, space_nxt;
    logic                fire_q, fire_nxt;
    logic [SUM_W-1:0]    step_sum;

    logic                tick_c;
    logic                key_dir_c;
    logic                key_space_c;
    dir_t                key_code_c;

    // Move toward a lower bound without wrapping below it
    function automatic logic [POS_W-1:0] dec_clamp(input logic [POS_W-1:0] pos,
                                                   input logic [STEP_W-1:0] stp,
                                                   input int unsigned lo);
        if (EXT_W'(pos) < EXT_W'(lo) + EXT_W'(stp)) dec_clamp = POS_W'(lo);
        else                                       dec_clamp = pos - POS_W'(stp);
    endfunction

    // Move toward an upper bound without exceeding it
    function automatic logic [POS_W-1:0] inc_clamp(input logic [POS_W-1:0] pos,
                                                   input logic [STEP_W-1:0] stp,
                                                   input int unsigned hi);
        logic [EXT_W-1:0] sum;
        sum = EXT_W'(pos) + EXT_W'(stp);
        if (sum > EXT_W'(hi)) inc_clamp = POS_W'(hi);
        else                  inc_clamp = POS_W'(sum);
    endfunction

    // Force a loaded coordinate into its bounds
    function automatic logic [POS_W-1:0] rng_clamp(input logic [POS_W-1:0] pos,
                                                   input int unsigned lo,
                                                   input int unsigned hi);
        if (pos < POS_W'(lo))      rng_clamp = POS_W'(lo);
        else if (pos > POS_W'(hi)) rng_clamp = POS_W'(hi);
        else                       rng_clamp = pos;
    endfunction

    assign tick_c = (bus.hcount == 11'(H_LAST)) && (bus.vcount == 11'(V_LAST));

    // Decode the ASCII strobe into a direction or space event
    always_comb begin
        key_dir_c   = 1'b0;
        key_space_c = 1'b0;
        key_code_c  = D_LEFT;
        if (bus.ascii_new) begin
            case (bus.ascii_out)
                7'h61, 7'h41: begin key_dir_c = 1'b1; key_code_c = D_LEFT;  end
                7'h64, 7'h44: begin key_dir_c = 1'b1; key_code_c = D_RIGHT; end
                7'h77, 7'h57: begin key_dir_c = 1'b1; key_code_c = D_UP;    end
                7'h73, 7'h53: begin key_dir_c = 1'b1; key_code_c = D_DOWN;  end
                7'h20:        key_space_c = 1'b1;
                default:      ;
            endcase
        end
    end

    // Next-state: space/fire at the tick, then load-or-move, then key reloads
    always_comb begin
        state_nxt      = state;
        dir_nxt        = dir;
        dir_hold_nxt   = dir_hold;
        space_hold_nxt = space_hold;
        fire_req_nxt   = fire_req;
        step_nxt       = step_cur;
        run_cnt_nxt    = run_cnt;
        x_nxt          = x_pos;
        y_nxt          = y_pos;
        space_nxt      = space_q;
        fire_nxt       = 1'b0;
        step_sum       = SUM_W'(step_cur) + SUM_W'(STEP);

        if (tick_c) begin
            space_nxt    = (space_hold != '0);
            if (space_hold != '0) space_hold_nxt = space_hold - HOLD_W'(1);
            fire_nxt     = fire_req;
            fire_req_nxt = 1'b0;
        end

        if (bus.pos_load) begin
            x_nxt        = rng_clamp(bus.x_pos_in, X_MIN, X_MAX);
            y_nxt        = rng_clamp(bus.y_pos_in, Y_MIN, Y_MAX);
            state_nxt    = S_IDLE;
            dir_hold_nxt = '0;
            step_nxt     = STEP_W'(STEP);
            run_cnt_nxt  = '0;
        end else if (tick_c) begin
            if (dir_hold != '0) begin
                state_nxt    = S_MOVE;
                dir_hold_nxt = dir_hold - HOLD_W'(1);
                case (dir)
                    D_LEFT:  x_nxt = dec_clamp(x_pos, step_cur, X_MIN);
                    D_RIGHT: x_nxt = inc_clamp(x_pos, step_cur, X_MAX);
                    D_UP:    y_nxt = dec_clamp(y_pos, step_cur, Y_MIN);
                    default: y_nxt = inc_clamp(y_pos, step_cur, Y_MAX);
                endcase
                if (run_cnt == RUN_W'(ACCEL_FRAMES - 1)) begin
                    run_cnt_nxt = '0;
                    step_nxt    = (step_sum > SUM_W'(STEP_MAX)) ? STEP_W'(STEP_MAX)
                                                                : STEP_W'(step_sum);
                end else begin
                    run_cnt_nxt = run_cnt + RUN_W'(1);
                end
            end else if (state == S_MOVE) begin
                state_nxt   = S_IDLE;
                step_nxt    = STEP_W'(STEP);
                run_cnt_nxt = '0;
            end
        end

        // Reloads land after the tick's decrement; a concurrent load drops the key
        if (!bus.pos_load) begin
            if (key_dir_c) begin
                if (key_code_c != dir) begin
                    step_nxt    = STEP_W'(STEP);
                    run_cnt_nxt = '0;
                end
                dir_nxt      = key_code_c;
                dir_hold_nxt = HOLD_W'(HOLD_FRAMES);
            end
            if (key_space_c) begin
                space_hold_nxt = HOLD_W'(HOLD_FRAMES);
                fire_req_nxt   = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dir        <= D_LEFT;
            dir_hold   <= '0;
            space_hold <= '0;
            fire_req   <= 1'b0;
            step_cur   <= STEP_W'(STEP);
            run_cnt    <= '0;
            x_pos      <= POS_W'(X_RST);
            y_pos      <= POS_W'(Y_RST);
            space_q    <= 1'b0;
            fire_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            dir        <= dir_nxt;
            dir_hold   <= dir_hold_nxt;
            space_hold <= space_hold_nxt;
            fire_req   <= fire_req_nxt;
            step_cur   <= step_nxt;
            run_cnt    <= run_cnt_nxt;
            x_pos      <= x_nxt;
            y_pos      <= y_nxt;
            space_q    <= space_nxt;
            fire_q     <= fire_nxt;
        end
    end

    assign bus.x_pos_k = x_pos;
    assign bus.y_pos_k = y_pos;
    assign bus.space   = space_q;
    assign bus.fire    = fire_q;
    assign bus.moving  = (state == S_MOVE);
endmodule

// File: tb/tb_keyboard_mover.sv
// Randomised + directed bench for keyboard_mover; frames are compressed so the
// tick (hcount=799, vcount=599) arrives every few clocks.
module tb_keyboard_mover;
    localparam int X_MIN = 1, X_MAX = 763, Y_MIN = 1, Y_MAX = 563;
    localparam int X_RST = 380, Y_RST = 500;
    localparam int STEP = 2, STEP_MAX = 8, ACCEL_FRAMES = 16, HOLD_FRAMES = 6;
    localparam int FL = 6;

    typedef struct {
        int x;
        int y;
        bit space;
        bit fire;
        bit moving;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    // Reference model state
    int m_x, m_y, m_dir, m_hold, m_shold, m_step, m_moves;
    bit m_moving, m_space, m_fire, m_freq;

    keyboard_mover_if #(.POS_W(12)) bus ();

    keyboard_mover dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lim(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // One clock of behaviour; key index: 0 left, 1 right, 2 up, 3 down, 4 space
    task automatic model_cycle(input bit r, input bit pl, input bit tk, input bit kn,
                               input logic [6:0] kc, input int xi, input int yi);
        int key;
        if (r) begin
            m_x = X_RST; m_y = Y_RST; m_hold = 0; m_shold = 0; m_freq = 0;
            m_step = STEP; m_moves = 0; m_moving = 0; m_space = 0; m_fire = 0;
        end else begin
            key = -1;
            if (kn) begin
                case (kc)
                    7'h61, 7'h41: key = 0;
                    7'h64, 7'h44: key = 1;
                    7'h77, 7'h57: key = 2;
                    7'h73, 7'h53: key = 3;
                    7'h20:        key = 4;
                    default:      key = -1;
                endcase
            end
            m_fire = 0;
            if (tk) begin
                m_space = (m_shold > 0);
                if (m_shold > 0) m_shold = m_shold - 1;
                m_fire = m_freq;
                m_freq = 0;
            end
            if (pl) begin
                m_x = lim(xi, X_MIN, X_MAX);
                m_y = lim(yi, Y_MIN, Y_MAX);
                m_moving = 0; m_hold = 0; m_step = STEP; m_moves = 0;
                key = -1;
            end else if (tk) begin
                if (m_hold > 0) begin
                    case (m_dir)
                        0:       m_x = lim(m_x - m_step, X_MIN, X_MAX);
                        1:       m_x = lim(m_x + m_step, X_MIN, X_MAX);
                        2:       m_y = lim(m_y - m_step, Y_MIN, Y_MAX);
                        default: m_y = lim(m_y + m_step, Y_MIN, Y_MAX);
                    endcase
                    m_hold   = m_hold - 1;
                    m_moving = 1;
                    m_moves  = m_moves + 1;
                    if (m_moves == ACCEL_FRAMES) begin
                        m_moves = 0;
                        m_step  = (m_step + STEP > STEP_MAX) ? STEP_MAX : m_step + STEP;
                    end
                end else if (m_moving) begin
                    m_moving = 0; m_step = STEP; m_moves = 0;
                end
            end
            if (key >= 0 && key < 4) begin
                if (key != m_dir) begin
                    m_step = STEP; m_moves = 0;
                end
                m_dir  = key;
                m_hold = HOLD_FRAMES;
            end else if (key == 4) begin
                m_shold = HOLD_FRAMES;
                m_freq  = 1;
            end
        end
        exp_q.push_back('{x: m_x, y: m_y, space: m_space, fire: m_fire, moving: m_moving});
    endtask

    // Drive one clock of inputs at the falling edge and record what must follow
    task automatic cyc(input bit r, input bit pl, input bit tk, input bit kn,
                       input logic [6:0] kc, input int xi, input int yi);
        @(negedge clk);
        rst           = r;
        bus.pos_load  = pl;
        bus.ascii_new = kn;
        bus.ascii_out = kc;
        bus.x_pos_in  = 12'(xi);
        bus.y_pos_in  = 12'(yi);
        if (tk) begin
            bus.hcount = 11'(799);
            bus.vcount = 11'(599);
        end else begin
            case ($urandom_range(0, 2))
                0: begin bus.hcount = 11'(799); bus.vcount = 11'($urandom_range(0, 598)); end
                1: begin bus.hcount = 11'($urandom_range(0, 798)); bus.vcount = 11'(599); end
                default: begin
                    bus.hcount = 11'($urandom_range(0, 798));
                    bus.vcount = 11'($urandom_range(0, 598));
                end
            endcase
        end
        model_cycle(r, pl, tk, kn, kc, xi, yi);
    endtask

    task automatic frame_k(input logic [6:0] kc, input bit kn, input int kpos);
        for (int i = 0; i < FL; i++) cyc(1'b0, 1'b0, i == FL - 1, kn && (i == kpos), kc, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic logic [6:0] pick_key();
        case ($urandom_range(0, 11))
            0:       return 7'h61;
            1:       return 7'h41;
            2:       return 7'h64;
            3:       return 7'h44;
            4:       return 7'h77;
            5:       return 7'h57;
            6:       return 7'h73;
            7:       return 7'h53;
            8, 9:    return 7'h20;
            10:      return 7'h62;
            default: return 7'h00;
        endcase
    endfunction

    // Scoreboard monitor: one expected output set per clock
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.x_pos_k !== 12'(e.x) || bus.y_pos_k !== 12'(e.y) ||
                    bus.space !== e.space || bus.fire !== e.fire || bus.moving !== e.moving) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got x=%0d y=%0d space=%b fire=%b moving=%b expected x=%0d y=%0d space=%b fire=%b moving=%b",
                             $time, bus.x_pos_k, bus.y_pos_k, bus.space, bus.fire, bus.moving,
                             e.x, e.y, e.space, e.fire, e.moving);
                end
            end
        end
    end

    initial begin
        bit          r, pl, kn;
        logic [6:0]  kc;
        int          len, xi, yi;

        errors = 0; checks = 0; m_dir = 0;
        rst = 1'b1;
        bus.ascii_new = 1'b0; bus.ascii_out = '0; bus.hcount = '0; bus.vcount = '0;
        bus.pos_load = 1'b0; bus.x_pos_in = '0; bus.y_pos_in = '0;

        // Reset then quiet frames
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (3) frame_k(0, 0, 0);
        settle();
        chk("reset_x", int'(bus.x_pos_k), 380);
        chk("reset_y", int'(bus.y_pos_k), 500);
        chk("reset_moving", int'(bus.moving), 0);

        // Single 'd' press: six moves then stop
        frame_k(7'h64, 1, 0);
        repeat (5) frame_k(0, 0, 0);
        settle();
        chk("d_x_after6", int'(bus.x_pos_k), 392);
        chk("d_moving_after6", int'(bus.moving), 1);
        frame_k(0, 0, 0);
        settle();
        chk("d_moving_tick7", int'(bus.moving), 0);
        chk("d_x_tick7", int'(bus.x_pos_k), 392);

        // 'A' every two frames accelerates, then 'w' restarts at base step
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int f = 0; f < 40; f++) frame_k(7'h41, (f % 2) == 0, 0);
        settle();
        chk("accel_x", int'(bus.x_pos_k), 236);
        frame_k(7'h77, 1, 0);
        settle();
        chk("w_y", int'(bus.y_pos_k), 498);
        chk("w_x", int'(bus.x_pos_k), 236);

        // Load and clamp at bounds
        cyc(0, 1, 0, 0, 0, 5, 2);
        settle();
        chk("load_x", int'(bus.x_pos_k), 5);
        chk("load_y", int'(bus.y_pos_k), 2);
        repeat (3) frame_k(7'h61, 1, 0);
        settle();
        chk("clamp_xmin", int'(bus.x_pos_k), 1);
        cyc(0, 1, 0, 0, 0, 900, 2);
        settle();
        chk("load_clamp_xmax", int'(bus.x_pos_k), 763);
        cyc(0, 1, 0, 0, 0, 100, 562);
        frame_k(7'h73, 1, 0);
        settle();
        chk("clamp_ymax", int'(bus.y_pos_k), 563);

        // Two spaces in one frame give one fire; space stays high six ticks
        cyc(0, 1, 0, 0, 0, 100, 100);
        for (int i = 0; i < FL; i++) cyc(0, 0, i == FL - 1, i == 0 || i == 2, 7'h20, 0, 0);
        settle();
        chk("fire_at_tick", int'(bus.fire), 1);
        chk("space_at_tick", int'(bus.space), 1);
        repeat (5) frame_k(0, 0, 0);
        settle();
        chk("space_tick6", int'(bus.space), 1);
        frame_k(0, 0, 0);
        settle();
        chk("space_tick7", int'(bus.space), 0);

        // Key in the tick cycle applies after that tick's move
        cyc(0, 1, 0, 0, 0, 100, 100);
        frame_k(7'h64, 1, 0);
        frame_k(7'h77, 1, FL - 1);
        settle();
        chk("tickkey_x", int'(bus.x_pos_k), 104);
        chk("tickkey_y", int'(bus.y_pos_k), 100);
        frame_k(0, 0, 0);
        settle();
        chk("tickkey_next_y", int'(bus.y_pos_k), 98);

        // Reset while moving with a fire pending
        cyc(0, 0, 0, 1, 7'h20, 0, 0);
        cyc(0, 0, 0, 1, 7'h64, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("rst_mid_x", int'(bus.x_pos_k), 380);
        chk("rst_mid_moving", int'(bus.moving), 0);
        repeat (3) frame_k(0, 0, 0);

        // Random traffic
        for (int f = 0; f < 250; f++) begin
            len = $urandom_range(2, 8);
            for (int i = 0; i < len; i++) begin
                kn = ($urandom_range(0, 5) == 0);
                kc = pick_key();
                pl = ($urandom_range(0, 80) == 0);
                r  = ($urandom_range(0, 500) == 0);
                xi = $urandom_range(0, 1000);
                yi = $urandom_range(0, 1000);
                cyc(r, pl, i == len - 1, kn, kc, xi, yi);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
